// File: rtl/mem_responder.sv
// Single-outstanding memory responder: a valid/ready request channel feeds a
// fixed-latency word memory with byte strobes; responses are held until accepted.
module mem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt;
  logic               cap_wen;
  logic [29:0]        cap_word;
  logic [31:0]        cap_wdata;
  logic [3:0]         cap_wmask;
  logic [ADDR_W-1:0]  idx;
  logic               oor;
  logic               access;
  logic               addr_lsb_unused;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  assign addr_lsb_unused = ^req_addr[1:0];
  assign idx    = cap_word[ADDR_W-1:0];
  assign oor    = (cap_word >> ADDR_W) != '0;
  assign access = (state == BUSY) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_wen   <= req_wen;
            cap_word  <= req_addr[31:2];
            cap_wdata <= req_wdata;
            cap_wmask <= req_wmask;
            cnt       <= 4'(LATENCY - 1);
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_err   <= oor;
            resp_rdata <= (!cap_wen && !oor) ? mem[idx] : '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory has no reset; the write is gated by rst so a reset on the access
  // edge still drops the request.
  always_ff @(posedge clk) begin
    if (!rst && access && cap_wen && !oor) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (cap_wmask[i]) mem[idx][8*i +: 8] <= cap_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default instance plus LATENCY=1 and
// LATENCY=15 instances for timing checks.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wen, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        v1, rr1, rdy1, rv1, err1;
  logic [31:0] rd1;
  logic        v15, rr15, rdy15, rv15, err15;
  logic [31:0] rd15;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  mem_responder #(.ADDR_W(10), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .req_valid(v1), .req_ready(rdy1), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(rv1), .resp_ready(rr1),
    .resp_rdata(rd1), .resp_err(err1)
  );

  mem_responder #(.ADDR_W(10), .LATENCY(15)) u_l15 (
    .clk(clk), .rst(rst),
    .req_valid(v15), .req_ready(rdy15), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(rv15), .resp_ready(rr15),
    .resp_rdata(rd15), .resp_err(err15)
  );

  // Drives one transaction on the default instance; lat = edges from accept
  // to the first edge after which resp_valid is seen high (40 on timeout).
  task automatic do_txn(input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        output logic [31:0] rdata, output logic err,
                        output int lat);
    int n;
    @(negedge clk);
    req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
    rdata = resp_rdata;
    err   = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    n_cmp++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    n_cmp++;
    if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_resp_rdata got=%h exp=0", resp_rdata); end
    n_cmp++;
    if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err got=%b exp=0", resp_err); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic er; int lat;
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    n_cmp++;
    if (lat != 2 || rd !== 32'h0 || er !== 1'b0) begin
      n_fail++; $display("FAIL wr_resp lat=%0d rdata=%h err=%b exp lat=2 rdata=0 err=0", lat, rd, er);
    end
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (lat != 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++; $display("FAIL rd_resp lat=%0d rdata=%h err=%b exp lat=2 rdata=deadbeef err=0", lat, rd, er);
    end
    // Byte address low bits ignored: 0x13 hits the same word.
    do_txn(1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_unaligned got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_partial;
    logic [31:0] rd; logic er; int lat;
    do_txn(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    do_txn(1'b1, 32'h20, 32'hAABBCCDD, 4'h6, rd, er, lat);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h11BBCC44) begin n_fail++; $display("FAIL partial_wr got=%h exp=11bbcc44", rd); end
    do_txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    n_cmp++;
    if (lat != 2 || er !== 1'b0 || rd !== 32'h0) begin
      n_fail++; $display("FAIL zero_mask_resp lat=%0d rdata=%h err=%b exp lat=2 rdata=0 err=0", lat, rd, er);
    end
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h11BBCC44) begin n_fail++; $display("FAIL zero_mask_mem got=%h exp=11bbcc44", rd); end
  endtask

  task automatic test_backpressure;
    int n;
    @(negedge clk);
    req_wen = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_wmask = 4'h0;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(negedge clk);
    // Accepted; the next request sits on the bus during BUSY/RESP.
    req_addr = 32'h20;
    n = 0;
    while (!resp_valid && n < 40) begin @(negedge clk); n++; end
    n_cmp++;
    if (n != 2) begin n_fail++; $display("FAIL bp_latency got=%0d exp=2", n); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d valid=%b rdata=%h err=%b ready=%b exp 1/deadbeef/0/0",
                 i, resp_valid, resp_rdata, resp_err, req_ready);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_no_reuse valid=%b ready=%b exp valid=0 ready=1", resp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept ready=%b exp=0", req_ready); end
    n = 0;
    while (!resp_valid && n < 40) begin @(negedge clk); n++; end
    n_cmp++;
    if (n != 2 || resp_rdata !== 32'h11BBCC44) begin
      n_fail++; $display("FAIL bp_second_resp lat=%0d rdata=%h exp lat=2 rdata=11bbcc44", n, resp_rdata);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd; logic er; int lat;
    do_txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat);
    do_txn(1'b1, 32'h00001000, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    n_cmp++;
    if (lat != 2 || er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL oor_wr lat=%0d rdata=%h err=%b exp lat=2 rdata=0 err=1", lat, rd, er);
    end
    do_txn(1'b0, 32'h80000000, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL oor_rd rdata=%h err=%b exp rdata=0 err=1", rd, er);
    end
    do_txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL oor_mem_intact rdata=%h err=%b exp rdata=cafef00d err=0", rd, er);
    end
    do_txn(1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL top_word_in_range err=%b exp=0", er); end
  endtask

  task automatic test_reset_busy;
    logic [31:0] rd; logic er; int lat;
    logic seen;
    do_txn(1'b1, 32'h40, 32'h0BADC0DE, 4'hF, rd, er, lat);
    @(negedge clk);
    req_wen = 1'b1; req_addr = 32'h40; req_wdata = 32'h12345678; req_wmask = 4'hF;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rb_accept ready=%b exp=0", req_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rb_no_resp seen=%b exp=0", seen); end
    do_txn(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h0BADC0DE) begin n_fail++; $display("FAIL rb_mem got=%h exp=0badc0de", rd); end
  endtask

  task automatic test_reset_resp;
    int n;
    @(negedge clk);
    req_wen = 1'b0; req_addr = 32'h10; req_valid = 1'b1; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rr_discard valid=%b rdata=%h exp 0/0", resp_valid, resp_rdata);
    end
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rr_idle valid=%b ready=%b exp 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic test_latency_sweep;
    @(negedge clk);
    req_wen = 1'b0; req_addr = 32'h8; req_wdata = 32'h0; req_wmask = 4'h0;
    v1 = 1'b1;
    n_cmp++;
    if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL l1_ready got=%b exp=1", rdy1); end
    @(negedge clk);
    v1 = 1'b0;
    n_cmp++;
    if (rv1 !== 1'b0) begin n_fail++; $display("FAIL l1_k0 valid=%b exp=0", rv1); end
    @(negedge clk);
    n_cmp++;
    if (rv1 !== 1'b1) begin n_fail++; $display("FAIL l1_k1 valid=%b exp=1", rv1); end
    rr1 = 1'b1;
    @(negedge clk);
    rr1 = 1'b0;

    v15 = 1'b1;
    n_cmp++;
    if (rdy15 !== 1'b1) begin n_fail++; $display("FAIL l15_ready got=%b exp=1", rdy15); end
    @(negedge clk);
    v15 = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      n_cmp++;
      if (rv15 !== (k == 15)) begin
        n_fail++; $display("FAIL l15_k%0d valid=%b exp=%0d", k, rv15, (k == 15));
      end
      if (k != 15) @(negedge clk);
    end
    rr15 = 1'b1;
    @(negedge clk);
    rr15 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    resp_ready = 1'b0;
    v1 = 1'b0; rr1 = 1'b0; v15 = 1'b0; rr15 = 1'b0;
    test_reset;
    test_write_read;
    test_partial;
    test_backpressure;
    test_out_of_range;
    test_reset_busy;
    test_reset_resp;
    test_latency_sweep;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
